// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port, counts retired instructions and halts on unsupported encodings.
module multicycle_ctrl #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           f3,
    input  logic                 f7,
    input  logic                 zero,
    input  logic                 memReady,
    output logic                 pcWrite,
    output logic                 adrSrc,
    output logic                 memWrite,
    output logic                 irWrite,
    output logic                 regWrite,
    output logic [1:0]           resSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           immSrc,
    output logic [2:0]           ALUControl,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ERROR
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;

    logic       f3_ok;
    logic [2:0] funct_alu;
    logic       retire;
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    // Immediate format depends only on the opcode.
    always_comb begin
        immSrc = 2'b00;
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    // ALU operation for R/I arithmetic; f7 only selects sub for R-type.
    always_comb begin
        f3_ok     = 1'b1;
        funct_alu = ALU_ADD;
        case (f3)
            3'b000:  funct_alu = ((op == OP_R) && f7) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: f3_ok     = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adrSrc        = 1'b0;
        resSrc        = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        illegal       = 1'b0;
        retire        = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                resSrc       = 2'b10;
                pc_write_raw = memReady;
                ir_write_raw = memReady;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = f3_ok ? S_EXECR : S_ERROR;
                    OP_I:         state_d = f3_ok ? S_EXECI : S_ERROR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resSrc        = 2'b01;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                if (memReady) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                ALUControl   = ALU_SUB;
                pc_write_raw = zero;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_ALUWB;
            end
            S_ERROR: begin
                illegal = 1'b1;
            end
            default: state_d = S_ERROR;
        endcase

        instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
    end

    // Enables are gated by rst_n so nothing can write while reset is held.
    assign pcWrite  = pc_write_raw  & rst_n;
    assign memWrite = mem_write_raw & rst_n;
    assign irWrite  = ir_write_raw  & rst_n;
    assign regWrite = reg_write_raw & rst_n;
    assign instret  = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-computed control words per
// cycle, and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = 7'd0;
    logic [2:0]  f3 = 3'd0;
    logic        f7 = 1'b0;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0]  resSrc, ALUSrcA, ALUSrcB, immSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;

    multicycle_ctrl #(.INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .regWrite(regWrite), .resSrc(resSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .immSrc(immSrc), .ALUControl(ALUControl), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    logic [31:0] cnt_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  cur_imm = 2'b00;

    // Word order: pcW adr memW irW regW res[2] A[2] B[2] | imm[2] | alu[3] illegal
    function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, res, a, b, alu, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] got, want;
            logic [31:0] want_cnt;
            string       t;
            want     = exp_q.pop_front();
            want_cnt = cnt_q.pop_front();
            t        = tag_q.pop_front();
            got = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resSrc, ALUSrcA, ALUSrcB,
                   immSrc, ALUControl, illegal};
            checks++;
            if (got !== want || instret !== want_cnt) begin
                failures++;
                $display("FAIL %s ctl got=%05h exp=%05h instret got=%0d exp=%0d",
                         t, got, want, instret, want_cnt);
            end
        end
    end

    task automatic push(input string tag, input logic [14:0] c, input logic [31:0] ir);
        exp_q.push_back({c[14:4], cur_imm, c[3:0]});
        cnt_q.push_back(ir);
        tag_q.push_back(tag);
    endtask

    // One clock cycle: drive inputs, queue the expectation, return just after the next edge.
    task automatic cyc(input string tag, input logic mr, input logic z,
                       input logic [14:0] c, input logic [31:0] ir);
        memReady = mr;
        zero     = z;
        push(tag, c, ir);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic s,
                             input logic [1:0] imm);
        op      = o;
        f3      = f;
        f7      = s;
        cur_imm = imm;
    endtask

    // Asserts reset mid-cycle; the check lands before the next clock edge.
    task automatic do_reset(input string tag, input logic [14:0] c);
        rst_n    = 1'b0;
        memReady = 1'b1;
        #1;
        push(tag, c, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [14:0] fe, fe_st, dec, madr, mrd, mwb, mwr, awb, jal, err;

    initial begin
        fe    = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        fe_st = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        dec   = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
        madr  = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        mrd   = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        mwb   = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
        mwr   = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        awb   = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        jal   = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
        err   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);

        @(posedge clk);
        #1;
        do_reset("reset_init", fe_st);

        set_instr(7'b0010011, 3'b000, 1'b0, 2'b00);  // addi
        cyc("addi_fetch", 1, 0, fe, 0);
        cyc("addi_decode", 1, 0, dec, 0);
        cyc("addi_execi", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0), 0);
        cyc("addi_aluwb", 1, 0, awb, 0);

        set_instr(7'b0000011, 3'b010, 1'b0, 2'b00);  // lw, two stall cycles
        cyc("lw_fetch", 1, 0, fe, 1);
        cyc("lw_decode", 1, 0, dec, 1);
        cyc("lw_memadr", 1, 0, madr, 1);
        cyc("lw_memread_stall1", 0, 0, mrd, 1);
        cyc("lw_memread_stall2", 0, 0, mrd, 1);
        cyc("lw_memread_done", 1, 0, mrd, 1);
        cyc("lw_memwb", 1, 0, mwb, 1);

        set_instr(7'b1100011, 3'b000, 1'b0, 2'b10);  // beq taken
        cyc("beq1_fetch", 1, 0, fe, 2);
        cyc("beq1_decode", 1, 0, dec, 2);
        cyc("beq1_taken", 1, 1, mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 2);
        cyc("beq2_fetch_stall", 0, 1, fe_st, 3);    // beq not taken
        cyc("beq2_fetch", 1, 1, fe, 3);
        cyc("beq2_decode", 1, 0, dec, 3);
        cyc("beq2_not_taken", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 3);

        set_instr(7'b0110011, 3'b000, 1'b1, 2'b00);  // sub
        cyc("sub_fetch", 1, 0, fe, 4);
        cyc("sub_decode", 1, 0, dec, 4);
        cyc("sub_execr", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0), 4);
        cyc("sub_aluwb", 1, 0, awb, 4);

        set_instr(7'b0110011, 3'b110, 1'b0, 2'b00);  // or
        cyc("or_fetch", 1, 0, fe, 5);
        cyc("or_decode", 1, 0, dec, 5);
        cyc("or_execr", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 0), 5);
        cyc("or_aluwb", 1, 0, awb, 5);

        set_instr(7'b0010011, 3'b000, 1'b1, 2'b00);  // addi with instr[30] set
        cyc("addi7_fetch", 1, 0, fe, 6);
        cyc("addi7_decode", 1, 0, dec, 6);
        cyc("addi7_execi", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0), 6);
        cyc("addi7_aluwb", 1, 0, awb, 6);

        set_instr(7'b1101111, 3'b000, 1'b0, 2'b11);  // jal
        cyc("jal_fetch", 1, 0, fe, 7);
        cyc("jal_decode", 1, 0, dec, 7);
        cyc("jal_jal", 1, 0, jal, 7);
        cyc("jal_aluwb", 1, 0, awb, 7);

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);  // sw, one stall
        cyc("sw_fetch", 1, 0, fe, 8);
        cyc("sw_decode", 1, 0, dec, 8);
        cyc("sw_memadr", 1, 0, madr, 8);
        cyc("sw_memwrite_stall", 0, 0, mwr, 8);
        cyc("sw_memwrite_done", 1, 0, mwr, 8);

        set_instr(7'b0110011, 3'b111, 1'b0, 2'b00);  // and
        cyc("and_fetch", 1, 0, fe, 9);
        cyc("and_decode", 1, 0, dec, 9);
        cyc("and_execr", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0), 9);
        cyc("and_aluwb", 1, 0, awb, 9);

        set_instr(7'b0010011, 3'b010, 1'b0, 2'b00);  // slti
        cyc("slti_fetch", 1, 0, fe, 10);
        cyc("slti_decode", 1, 0, dec, 10);
        cyc("slti_execi", 1, 0, mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0), 10);
        cyc("slti_aluwb", 1, 0, awb, 10);

        set_instr(7'b0110111, 3'b000, 1'b0, 2'b00);  // lui: unsupported
        cyc("lui_fetch", 1, 0, fe, 11);
        cyc("lui_decode", 1, 0, dec, 11);
        for (int i = 0; i < 10; i++) cyc($sformatf("lui_error%0d", i), 1, 1, err, 11);

        do_reset("reset_clears_error", fe_st);

        set_instr(7'b0100011, 3'b010, 1'b0, 2'b01);  // sw aborted by reset
        cyc("swr_fetch", 1, 0, fe, 0);
        cyc("swr_decode", 1, 0, dec, 0);
        cyc("swr_memadr", 1, 0, madr, 0);
        cyc("swr_memwrite_wait", 0, 0, mwr, 0);
        do_reset("swr_async_reset", fe_st);
        cyc("swr_refetch", 1, 0, fe, 0);
        cyc("swr_decode2", 1, 0, dec, 0);
        cyc("swr_memadr2", 1, 0, madr, 0);
        cyc("swr_memwrite2", 1, 0, mwr, 0);

        set_instr(7'b0110011, 3'b001, 1'b0, 2'b00);  // R-type with unsupported funct3
        cyc("badf3_fetch", 1, 0, fe, 1);
        cyc("badf3_decode", 1, 0, dec, 1);
        cyc("badf3_error0", 1, 0, err, 1);
        cyc("badf3_error1", 1, 0, err, 1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
